// File: rtl/hex_counter_display_pkg.sv
// Shared constants and types for the hex counter display: blanking codes,
// the active-low hex glyph table and the digit-index type.
package hex_counter_display_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    typedef logic [2:0] digit_idx_t;

    // Active-low segment patterns, bit0 = a ... bit6 = g, indexed by nibble value.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_counter_display_seg7_hex_decoder.sv
// Combinational 4-bit nibble to active-low 7-segment glyph lookup.
module seg7_hex_decoder
    import hex_counter_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = GLYPH_TABLE[nibble];

endmodule

// File: rtl/hex_counter_display.sv
// 32-bit up/down prescaled event counter shown on an 8-digit multiplexed
// common-anode display. Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module hex_counter_display
    import hex_counter_display_pkg::*;
#(
    parameter int TICK_DIV    = 100_000_000,
    parameter int REFRESH_DIV = 100_000,
    parameter int CNT_W       = 32
) (
    input  logic       sys_clk,
    input  logic       top_rst,
    input  logic       top_en,
    input  logic       top_sel,
    output logic [6:0] top_cc,
    output logic [7:0] top_an
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic [REF_W-1:0] ref_cnt;
    logic [CNT_W-1:0] count;
    digit_idx_t       idx;
    logic             run;
    logic             step;
    logic [3:0]       cur_nibble;
    logic [6:0]       cur_glyph;
    logic [6:0]       digit_cc;

    // Only an explicit 1 enables counting; anything else holds.
    assign run  = (top_en == 1'b1);
    assign step = run && (pre_cnt == PRE_MAX);

    always_ff @(posedge sys_clk) begin
        if (top_rst) begin
            pre_cnt <= '0;
            count   <= '0;
        end else if (run) begin
            if (step) begin
                pre_cnt <= '0;
                count   <= top_sel ? count - 1'b1 : count + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    // Scan keeps running with the counter disabled so the display never goes dark.
    always_ff @(posedge sys_clk) begin
        if (top_rst) begin
            ref_cnt <= '0;
            idx     <= '0;
        end else if (ref_cnt == REF_MAX) begin
            ref_cnt <= '0;
            idx     <= idx + 1'b1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    assign cur_nibble = count[{idx, 2'b00} +: 4];

    seg7_hex_decoder u_decoder (
        .nibble   (cur_nibble),
        .segments (cur_glyph)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_mask;
    logic                  zero_run;

    // A digit blanks when it and every higher nibble are zero; digit 0 never blanks.
    always_comb begin
        blank_mask = '0;
        zero_run   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run && (count[4*i +: 4] == 4'h0);
            blank_mask[i] = zero_run;
        end
    end

    assign digit_cc = blank_mask[idx] ? SEG_BLANK : cur_glyph;
`else
    assign digit_cc = cur_glyph;
`endif

    always_ff @(posedge sys_clk) begin
        if (top_rst) begin
            top_an <= AN_OFF;
            top_cc <= SEG_BLANK;
        end else begin
            top_an <= ~(8'b1 << idx);
            top_cc <= digit_cc;
        end
    end

endmodule

// File: tb/tb_hex_counter_display.sv
// Scoreboard bench for hex_counter_display with TICK_DIV=4, REFRESH_DIV=1;
// also exercises LEADING_ZERO_BLANK_EN when that macro is defined.
module tb_hex_counter_display;

    logic       sys_clk = 1'b0;
    logic       top_rst;
    logic       top_en;
    logic       top_sel;
    logic [6:0] top_cc;
    logic [7:0] top_an;

    int errors = 0;
    int checks = 0;

    logic [14:0] exp_q[$];

    logic [31:0] m_cnt;
    int          m_pre;
    int          m_idx;

    hex_counter_display #(
        .TICK_DIV    (4),
        .REFRESH_DIV (1),
        .CNT_W       (32)
    ) dut (
        .sys_clk (sys_clk),
        .top_rst (top_rst),
        .top_en  (top_en),
        .top_sel (top_sel),
        .top_cc  (top_cc),
        .top_an  (top_an)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [6:0] ref_digit(input logic [31:0] value, input int pos);
        logic [31:0] v;
        v = value;
`ifdef LEADING_ZERO_BLANK_EN
        if (pos != 0 && (v >> (4 * pos)) == 32'h0) return 7'h7F;
`endif
        return ref_glyph(v[4*pos +: 4]);
    endfunction

    // One clock: drive inputs at negedge, predict the registered outputs, then compare after the edge.
    task automatic cycle(input logic rst_v, input logic drive_ctl, input logic en_v, input logic sel_v);
        logic [14:0] e;
        logic [14:0] got;
        @(negedge sys_clk);
        top_rst = rst_v;
        if (drive_ctl) begin
            top_en  = en_v;
            top_sel = sel_v;
        end
        if (rst_v) begin
            exp_q.push_back({8'hFF, 7'h7F});
            m_cnt = '0;
            m_pre = 0;
            m_idx = 0;
        end else begin
            e = {~(8'b1 << m_idx), ref_digit(m_cnt, m_idx)};
            exp_q.push_back(e);
            if (top_en == 1'b1) begin
                if (m_pre == 3) begin
                    m_pre = 0;
                    m_cnt = top_sel ? m_cnt - 32'd1 : m_cnt + 32'd1;
                end else begin
                    m_pre++;
                end
            end
            m_idx = (m_idx + 1) % 8;
        end
        @(posedge sys_clk);
        #1;
        got = {top_an, top_cc};
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(rst_v ? "rst_out" : "scan_out", {17'h0, got}, {17'h0, e});
        end
    endtask

    task automatic run(input int n, input logic en_v, input logic sel_v);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, en_v, sel_v);
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            check("rst_count", dut.count, 32'h0);
        end
    endtask

    initial begin
        m_cnt = '0;
        m_pre = 0;
        m_idx = 0;

        // Reset with enable/direction left undriven.
        reset_cycles(10);

        // Count up: 40 enabled cycles give 10 steps.
        run(40, 1'b1, 1'b0);
        check("count_up", dut.count, 32'h0000_000A);
        run(8, 1'b0, 1'b0);

        // Down from zero wraps, then back up wraps to zero.
        reset_cycles(1);
        run(4, 1'b1, 1'b1);
        check("wrap_down", dut.count, 32'hFFFF_FFFF);
        run(8, 1'b0, 1'b1);
        run(4, 1'b1, 1'b0);
        check("wrap_up", dut.count, 32'h0);

        // Direction change mid-period keeps the prescaler phase.
        run(2, 1'b1, 1'b0);
        run(2, 1'b1, 1'b1);
        check("dir_mid_period", dut.count, 32'hFFFF_FFFF);
        run(4, 1'b1, 1'b0);

        // Hold: scan continues, counter frozen.
        run(100, 1'b0, 1'b0);
        check("hold", dut.count, 32'h0);

        // Random enable/direction stress against the model.
        for (int i = 0; i < 200; i++)
            run(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("random_count", dut.count, m_cnt);

        // Mid-operation reset at 0x13.
        reset_cycles(1);
        run(76, 1'b1, 1'b0);
        check("reach_13", dut.count, 32'h13);
        run(2, 1'b1, 1'b0);
        reset_cycles(1);
        run(3, 1'b1, 1'b0);
        check("resume_pre", dut.count, 32'h0);
        run(1, 1'b1, 1'b0);
        check("resume_step", dut.count, 32'h1);

        // Value 0xA5 then 0: scan all digits (exercises blanking when enabled).
        reset_cycles(1);
        run(660, 1'b1, 1'b0);
        check("reach_a5", dut.count, 32'hA5);
        run(16, 1'b0, 1'b0);
        reset_cycles(1);
        run(16, 1'b0, 1'b0);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
